// File: rtl/vault_phase_sequencer.sv
// Sequences NUM_PHASES phase FSMs in order, holding idle phases in reset, with retry and timeout limits.
// Optional macro VAULT_COOLDOWN_EN: lockout expires after COOLDOWN_CYCLES instead of being terminal.
module vault_phase_sequencer #(
  parameter int NUM_PHASES      = 4,
  parameter int MAX_TRIES       = 3,
  parameter int TIMEOUT_CYCLES  = 256,
  parameter int COOLDOWN_CYCLES = 1024,
  localparam int PHASE_W = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1,
  localparam int TRY_W   = $clog2(MAX_TRIES + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_PHASES-1:0] phase_done,
  input  logic [NUM_PHASES-1:0] phase_fail,
  output logic [NUM_PHASES-1:0] phase_rst,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic [PHASE_W-1:0]    cur_phase,
  output logic [TRY_W-1:0]      attempts_left,
  output logic                  phase_timeout,
  output logic                  vault_open,
  output logic                  vault_locked,
  output logic                  busy
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
  localparam logic [TRY_W-1:0]   TRIES_INIT = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0]   TRIES_ONE  = TRY_W'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_OPEN   = 3'd3;
  localparam logic [2:0] S_LOCKED = 3'd4;

  // Parameter range guard; an illegal configuration elaborates this empty block.
  if (NUM_PHASES < 2 || MAX_TRIES < 1 || COOLDOWN_CYCLES < 1) begin : g_invalid_params
  end

  logic [2:0]            state_reg;
  logic [2:0]            state_next;
  logic [PHASE_W-1:0]    cur_next;
  logic [TRY_W-1:0]      tries_next;
  logic [TIMER_W-1:0]    timer_reg;
  logic [TIMER_W-1:0]    timer_next;
  logic                  timeout_next;
  logic                  hit_fail;
  logic                  hit_done;
  logic                  hit_timeout;
  logic [NUM_PHASES-1:0] rst_next;
  logic [NUM_PHASES-1:0] en_next;

`ifdef VAULT_COOLDOWN_EN
  localparam int COOL_W = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN_CYCLES - 1);

  logic [COOL_W-1:0] cool_reg;
  logic [COOL_W-1:0] cool_next;
  logic              cool_expired;

  assign cool_expired = (cool_reg == COOL_LAST);
`endif

  // Only the active phase's flags matter; the rest are held in reset anyway.
  assign hit_fail    = phase_fail[cur_phase];
  assign hit_done    = phase_done[cur_phase];
  assign hit_timeout = (TIMEOUT_CYCLES != 0) && (timer_reg == TIMER_LAST);

  always_comb begin
    state_next   = state_reg;
    cur_next     = cur_phase;
    tries_next   = attempts_left;
    timer_next   = timer_reg;
    timeout_next = 1'b0;
`ifdef VAULT_COOLDOWN_EN
    cool_next    = '0;
`endif
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_ARM;
          cur_next   = '0;
          tries_next = TRIES_INIT;
          timer_next = '0;
        end
      end
      S_ARM: begin
        state_next = S_RUN;
        timer_next = '0;
      end
      S_RUN: begin
        timer_next = timer_reg + TIMER_W'(1);
        if (hit_fail || hit_timeout) begin
          timeout_next = ~hit_fail;
          timer_next   = '0;
          if (attempts_left == TRIES_ONE) begin
            tries_next = '0;
            state_next = S_LOCKED;
          end else begin
            tries_next = attempts_left - TRY_W'(1);
            cur_next   = '0;
            state_next = S_ARM;
          end
        end else if (hit_done) begin
          timer_next = '0;
          if (cur_phase == LAST_PHASE) begin
            state_next = S_OPEN;
          end else begin
            cur_next   = cur_phase + PHASE_W'(1);
            state_next = S_ARM;
          end
        end
      end
      S_OPEN: begin
        state_next = S_OPEN;
      end
      S_LOCKED: begin
`ifdef VAULT_COOLDOWN_EN
        cool_next = cool_reg + COOL_W'(1);
        if (cool_expired) begin
          state_next = S_IDLE;
          tries_next = TRIES_INIT;
          cur_next   = '0;
          cool_next  = '0;
        end
`else
        state_next = S_LOCKED;
`endif
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort never releases a lockout, so attempts_left cannot be refreshed that way.
    if (abort && (state_reg != S_LOCKED)) begin
      state_next   = S_IDLE;
      cur_next     = '0;
      tries_next   = TRIES_INIT;
      timer_next   = '0;
      timeout_next = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_phase
    assign en_next[gi]  = (state_next == S_RUN) && (cur_next == PHASE_W'(gi));
    assign rst_next[gi] = ~en_next[gi];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      timer_reg     <= '0;
      phase_rst     <= '1;
      phase_en      <= '0;
      cur_phase     <= '0;
      attempts_left <= TRIES_INIT;
      phase_timeout <= 1'b0;
      vault_open    <= 1'b0;
      vault_locked  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      phase_rst     <= rst_next;
      phase_en      <= en_next;
      cur_phase     <= cur_next;
      attempts_left <= tries_next;
      phase_timeout <= timeout_next;
      vault_open    <= (state_next == S_OPEN);
      vault_locked  <= (state_next == S_LOCKED);
      busy          <= (state_next == S_ARM) || (state_next == S_RUN);
    end
  end

`ifdef VAULT_COOLDOWN_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cool_reg <= '0;
    end else begin
      cool_reg <= cool_next;
    end
  end
`endif

endmodule

// File: tb/tb_vault_phase_sequencer.sv
// Scoreboard bench for vault_phase_sequencer: stimulus queues expected output snapshots with their cycle,
// a negedge monitor pops one whenever any output changes. Build with VAULT_COOLDOWN_EN to cover cooldown.
module tb_vault_phase_sequencer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [3:0] phase_done;
  logic [3:0] phase_fail;
  logic [3:0] phase_rst;
  logic [3:0] phase_en;
  logic [1:0] cur_phase;
  logic [1:0] attempts_left;
  logic       phase_timeout;
  logic       vault_open;
  logic       vault_locked;
  logic       busy;

  typedef struct {
    int          cyc;
    logic [15:0] obs;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] prev_obs;
  logic [15:0] now_obs;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  vault_phase_sequencer #(
    .NUM_PHASES(4),
    .MAX_TRIES(3),
    .TIMEOUT_CYCLES(16),
    .COOLDOWN_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .abort(abort),
    .phase_done(phase_done),
    .phase_fail(phase_fail),
    .phase_rst(phase_rst),
    .phase_en(phase_en),
    .cur_phase(cur_phase),
    .attempts_left(attempts_left),
    .phase_timeout(phase_timeout),
    .vault_open(vault_open),
    .vault_locked(vault_locked),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Snapshot layout: {phase_rst, phase_en, cur_phase, attempts_left, timeout, open, locked, busy}
  function automatic logic [15:0] mk(logic [3:0] rst, logic [3:0] en, logic [1:0] cur,
                                     logic [1:0] tries, logic to, logic op, logic lk, logic bz);
    return {rst, en, cur, tries, to, op, lk, bz};
  endfunction

  always @(negedge clk) begin
    now_obs = {phase_rst, phase_en, cur_phase, attempts_left, phase_timeout, vault_open, vault_locked, busy};
    if (now_obs !== prev_obs) begin
      prev_obs = now_obs;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, now_obs);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.obs !== now_obs || mon_e.cyc != cyc) begin
          n_fail++;
          $display("FAIL output_event got cyc=%0d obs=%b required cyc=%0d obs=%b",
                   cyc, now_obs, mon_e.cyc, mon_e.obs);
        end else begin
          $display("cyc=%0d obs=%b ok", cyc, now_obs);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(int c, logic [15:0] o);
    exp_t e;
    e.cyc = c;
    e.obs = o;
    exp_q.push_back(e);
  endtask

  task automatic push_arm(int c, logic [1:0] cur, logic [1:0] tries, logic to);
    push(c, mk(4'b1111, 4'b0000, cur, tries, to, 1'b0, 1'b0, 1'b1));
  endtask

  task automatic push_run(int c, logic [3:0] rst, logic [3:0] en, logic [1:0] cur, logic [1:0] tries);
    push(c, mk(rst, en, cur, tries, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  task automatic push_idle(int c, logic [1:0] tries);
    push(c, mk(4'b1111, 4'b0000, 2'd0, tries, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic do_start();
    push_arm(cyc + 1, 2'd0, 2'd3, 1'b0);
    push_run(cyc + 2, 4'b1110, 4'b0001, 2'd0, 2'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic advance(logic [3:0] dbits, logic [1:0] ncur, logic [3:0] nrst, logic [3:0] nen,
                         logic [1:0] tries);
    push_arm(cyc + 1, ncur, tries, 1'b0);
    push_run(cyc + 2, nrst, nen, ncur, tries);
    phase_done = dbits;
    tick();
    phase_done = 4'b0000;
    tick();
  endtask

  task automatic fail_now(logic [3:0] fbits, logic [3:0] dbits, logic [1:0] tries_after);
    push_arm(cyc + 1, 2'd0, tries_after, 1'b0);
    push_run(cyc + 2, 4'b1110, 4'b0001, 2'd0, tries_after);
    phase_fail = fbits;
    phase_done = dbits;
    tick();
    phase_fail = 4'b0000;
    phase_done = 4'b0000;
    tick();
  endtask

  initial begin
    int run_cyc;
    int lock_cyc;
    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    phase_done = 4'b0000;
    phase_fail = 4'b0000;
    push_idle(1, 2'd3);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Full pass; stray flags from non-active phases must be ignored
    do_start();
    tick();
    advance(4'b0001, 2'd1, 4'b1101, 4'b0010, 2'd3);
    phase_done = 4'b0001;
    phase_fail = 4'b1000;
    repeat (3) tick();
    phase_done = 4'b0000;
    phase_fail = 4'b0000;
    advance(4'b0010, 2'd2, 4'b1011, 4'b0100, 2'd3);
    advance(4'b0100, 2'd3, 4'b0111, 4'b1000, 2'd3);
    push(cyc + 1, mk(4'b1111, 4'b0000, 2'd3, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0));
    phase_done = 4'b1000;
    tick();
    phase_done = 4'b0000;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    push_idle(cyc + 1, 2'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // Fail in phase 2, then simultaneous done+fail in phase 1
    do_start();
    advance(4'b0001, 2'd1, 4'b1101, 4'b0010, 2'd3);
    advance(4'b0010, 2'd2, 4'b1011, 4'b0100, 2'd3);
    fail_now(4'b0100, 4'b0000, 2'd2);
    advance(4'b0001, 2'd1, 4'b1101, 4'b0010, 2'd2);
    fail_now(4'b0010, 4'b0010, 2'd1);

    // Abort in phase 2 wins over a same-cycle done
    advance(4'b0001, 2'd1, 4'b1101, 4'b0010, 2'd1);
    advance(4'b0010, 2'd2, 4'b1011, 4'b0100, 2'd1);
    push_idle(cyc + 1, 2'd3);
    abort = 1'b1;
    phase_done = 4'b0100;
    tick();
    abort = 1'b0;
    phase_done = 4'b0000;
    tick();

    // Reset during phase 1 restores attempts_left
    do_start();
    fail_now(4'b0001, 4'b0000, 2'd2);
    advance(4'b0001, 2'd1, 4'b1101, 4'b0010, 2'd2);
    push_idle(cyc + 1, 2'd3);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Three timeouts of 16 RUN cycles each lead to lockout
    do_start();
    run_cyc = cyc;
    push_arm(run_cyc + 16, 2'd0, 2'd2, 1'b1);
    push_run(run_cyc + 17, 4'b1110, 4'b0001, 2'd0, 2'd2);
    run_cyc = run_cyc + 17;
    push_arm(run_cyc + 16, 2'd0, 2'd1, 1'b1);
    push_run(run_cyc + 17, 4'b1110, 4'b0001, 2'd0, 2'd1);
    run_cyc = run_cyc + 17;
    lock_cyc = run_cyc + 16;
    push(lock_cyc, mk(4'b1111, 4'b0000, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0));
    push(lock_cyc + 1, mk(4'b1111, 4'b0000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
`ifdef VAULT_COOLDOWN_EN
    push_idle(lock_cyc + 8, 2'd3);
`endif
    while (cyc < lock_cyc + 2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    while (cyc < lock_cyc + 20) tick();
`ifndef VAULT_COOLDOWN_EN
    push_idle(cyc + 1, 2'd3);
`endif
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    do_start();
    repeat (4) tick();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events got=%0d left in queue required=0 (next cyc=%0d obs=%b)",
               exp_q.size(), exp_q[0].cyc, exp_q[0].obs);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
